fault_containment_ctrl: RTL and testbench

Parametrised per-segment fault containment controller with retry escalation, post-recovery hold-off and a lossless, backpressured event queue to the fault logger. Sits between the segment health monitors and the pipeline gating/soft-reset network. It is the memory-mapped control registers' consumer. Simultaneous events from multiple segments are serialised round-robin, not dropped.

---
 rtl/fault_containment_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_fault_containment_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_containment_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fault_containment_ctrl                                       |
// | Description : Per-segment fault containment controller. Each segment runs  |
// |               an OK/FAULT/ISO/HOLDOFF(/LOCKED) FSM that drives pipeline    |
// |               gating and soft-reset pulses. Events are held in a one-deep  |
// |               slot per segment, serialised round-robin into a FIFO and     |
// |               handed to the fault logger over a valid/ready handshake.     |
// | Options     : FAULT_CONTAIN_LOCKOUT_EN enables retry counting, the LOCKED  |
// |               state, F4/F5 events and clear_lock_i.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fault_containment_ctrl #(
  parameter int NUM_SEG     = 8,
  parameter int EVT_DEPTH   = 4,
  parameter int MAX_RETRY   = 3,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_SEG-1:0]         seg_fault_i,
  input  logic [NUM_SEG-1:0]         seg_recoverable_i,
  input  logic [NUM_SEG-1:0]         fence_enable_i,
  input  logic [NUM_SEG-1:0]         mask_isolate_i,
  input  logic [NUM_SEG-1:0]         clear_lock_i,
  input  logic                       ovf_clear_i,
  output logic [NUM_SEG-1:0]         seg_allow_o,
  output logic [NUM_SEG-1:0]         seg_soft_reset_o,
  output logic [NUM_SEG-1:0]         seg_locked_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [3:0]                 evt_severity_o,
  output logic [7:0]                 evt_code_o,
  output logic [$clog2(NUM_SEG)-1:0] evt_seg_o,
  output logic                       evt_overflow_o
);

  localparam int SEGW = $clog2(NUM_SEG);
  localparam int AW   = $clog2(EVT_DEPTH);
  localparam int PW   = 12 + SEGW;
  localparam int TW   = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  localparam logic [7:0]      c_code_f1   = 8'hF1;
  localparam logic [7:0]      c_code_f2   = 8'hF2;
  localparam logic [7:0]      c_code_f3   = 8'hF3;
  localparam logic [TW-1:0]   c_hold_load = TW'(HOLDOFF_CYC - 1);
  localparam logic [TW-1:0]   c_tmr_one   = TW'(1);
  localparam logic [SEGW-1:0] c_seg_one   = SEGW'(1);
  localparam logic [SEGW-1:0] c_seg_last  = SEGW'(NUM_SEG - 1);
  localparam logic [AW:0]     c_ptr_one   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_FAULT   = 3'd1,
    ST_ISO     = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_LOCKED  = 3'd4
  } seg_state_t;

  // Per-segment pending slots and arbitration results
  logic [NUM_SEG-1:0] w_slot_vld;
  logic [7:0]         w_slot_code [NUM_SEG];
  logic [3:0]         w_slot_sev  [NUM_SEG];
  logic [NUM_SEG-1:0] w_grant;
  logic [NUM_SEG-1:0] w_ovf_set;
  logic               w_gnt_any;
  logic [SEGW-1:0]    w_gnt_idx;
  logic [SEGW-1:0]    w_scan;
  logic [SEGW-1:0]    arb_ptr_q;

  // Event FIFO
  logic [PW-1:0]      mem_q [EVT_DEPTH];
  logic [AW:0]        wr_ptr_q;
  logic [AW:0]        rd_ptr_q;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_can_push;
  logic [PW-1:0]      w_wdata;
  logic [PW-1:0]      w_head;
  logic               ovf_q;

`ifdef FAULT_CONTAIN_LOCKOUT_EN
  localparam logic [7:0] c_code_f4   = 8'hF4;
  localparam logic [7:0] c_code_f5   = 8'hF5;
  localparam logic [3:0] c_max_retry = 4'(MAX_RETRY);
  logic [NUM_SEG-1:0]    w_locked;
  assign seg_locked_o = w_locked;
`else
  // Lockout is compiled out: clear_lock_i and MAX_RETRY have no function here
  logic w_unused_ok;
  assign w_unused_ok  = &{1'b0, clear_lock_i, 4'(MAX_RETRY)};
  assign seg_locked_o = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      seg_state_t      state_q, state_d;
      logic [TW-1:0]   timer_q, timer_d;
      logic            allow_q;
      logic            srst_q, srst_d;
      logic            slot_vld_q;
      logic [7:0]      slot_code_q;
      logic [3:0]      slot_sev_q;
      logic            w_fault_br;
      logic            w_ev_new;
      logic [7:0]      w_ev_code;
      logic [3:0]      w_ev_sev;
`ifdef FAULT_CONTAIN_LOCKOUT_EN
      logic [3:0]      retry_q, retry_d, w_retry_inc;
      logic            locked_q;
`endif

      // Next-state decode and event generation for this segment
      always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        srst_d     = 1'b0;
        w_fault_br = 1'b0;
        w_ev_new   = 1'b0;
        w_ev_code  = 8'h00;
        w_ev_sev   = 4'h0;
`ifdef FAULT_CONTAIN_LOCKOUT_EN
        retry_d     = retry_q;
        w_retry_inc = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;
`endif
        case (state_q)
          ST_OK: begin
            if (seg_fault_i[gi]) w_fault_br = 1'b1;
          end
          ST_FAULT: begin
            if (seg_recoverable_i[gi]) begin
              state_d   = ST_HOLDOFF;
              timer_d   = c_hold_load;
              srst_d    = 1'b1;
              w_ev_new  = 1'b1;
              w_ev_code = c_code_f2;
              w_ev_sev  = 4'd1;
            end
          end
          ST_ISO: begin
            if (seg_recoverable_i[gi]) begin
              state_d   = ST_HOLDOFF;
              timer_d   = c_hold_load;
              srst_d    = 1'b1;
              w_ev_new  = 1'b1;
              w_ev_code = c_code_f3;
              w_ev_sev  = 4'd1;
            end
          end
          ST_HOLDOFF: begin
            // A new fault wins over timer expiry
            if (seg_fault_i[gi])     w_fault_br = 1'b1;
            else if (timer_q == '0)  state_d    = ST_OK;
            else                     timer_d    = timer_q - c_tmr_one;
          end
`ifdef FAULT_CONTAIN_LOCKOUT_EN
          ST_LOCKED: begin
            if (clear_lock_i[gi]) begin
              state_d   = ST_OK;
              retry_d   = 4'd0;
              w_ev_new  = 1'b1;
              w_ev_code = c_code_f5;
              w_ev_sev  = 4'd1;
            end
          end
`endif
          default: state_d = ST_OK;
        endcase

        if (w_fault_br) begin
          w_ev_new = 1'b1;
`ifdef FAULT_CONTAIN_LOCKOUT_EN
          retry_d = w_retry_inc;
          if (w_retry_inc > c_max_retry) begin
            state_d   = ST_LOCKED;
            w_ev_code = c_code_f4;
            w_ev_sev  = 4'd3;
          end else begin
            state_d   = mask_isolate_i[gi] ? ST_ISO : ST_FAULT;
            w_ev_code = c_code_f1;
            w_ev_sev  = 4'd2;
          end
`else
          state_d   = mask_isolate_i[gi] ? ST_ISO : ST_FAULT;
          w_ev_code = c_code_f1;
          w_ev_sev  = 4'd2;
`endif
        end
      end

      // Segment state, registered gating outputs and the pending event slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q     <= ST_OK;
          timer_q     <= '0;
          allow_q     <= 1'b1;
          srst_q      <= 1'b0;
          slot_vld_q  <= 1'b0;
          slot_code_q <= 8'h00;
          slot_sev_q  <= 4'h0;
`ifdef FAULT_CONTAIN_LOCKOUT_EN
          retry_q     <= 4'd0;
          locked_q    <= 1'b0;
`endif
        end else begin
          state_q <= state_d;
          timer_q <= timer_d;
          srst_q  <= srst_d;
          case (state_d)
            ST_OK:    allow_q <= 1'b1;
            ST_FAULT: allow_q <= ~fence_enable_i[gi];
            default:  allow_q <= 1'b0;
          endcase
          // A fresh event always lands in the slot, even when the old one is granted now
          if (w_ev_new) begin
            slot_vld_q  <= 1'b1;
            slot_code_q <= w_ev_code;
            slot_sev_q  <= w_ev_sev;
          end else if (w_grant[gi]) begin
            slot_vld_q  <= 1'b0;
          end
`ifdef FAULT_CONTAIN_LOCKOUT_EN
          retry_q  <= retry_d;
          locked_q <= (state_d == ST_LOCKED);
`endif
        end
      end

      assign w_ovf_set[gi]        = w_ev_new & slot_vld_q & ~w_grant[gi];
      assign w_slot_vld[gi]       = slot_vld_q;
      assign w_slot_code[gi]      = slot_code_q;
      assign w_slot_sev[gi]       = slot_sev_q;
      assign seg_allow_o[gi]      = allow_q;
      assign seg_soft_reset_o[gi] = srst_q;
`ifdef FAULT_CONTAIN_LOCKOUT_EN
      assign w_locked[gi]         = locked_q;
`endif
    end
  endgenerate

  assign w_empty    = (wr_ptr_q == rd_ptr_q);
  assign w_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_pop      = ~w_empty & evt_ready_i;
  assign w_can_push = ~w_full | w_pop;

  // Round-robin search over pending slots starting at the pointer
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    w_scan    = '0;
    for (int off = 0; off < NUM_SEG; off++) begin
      w_scan = SEGW'((int'(arb_ptr_q) + off) % NUM_SEG);
      if (!w_gnt_any && w_can_push && w_slot_vld[w_scan]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
    if (w_gnt_any) w_grant[w_gnt_idx] = 1'b1;
  end

  // Arbiter pointer moves to one past the last grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arb_ptr_q <= '0;
    end else if (w_gnt_any) begin
      arb_ptr_q <= (w_gnt_idx == c_seg_last) ? '0 : w_gnt_idx + c_seg_one;
    end
  end

  assign w_wdata = {w_slot_sev[w_gnt_idx], w_slot_code[w_gnt_idx], w_gnt_idx};

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (w_gnt_any) mem_q[wr_ptr_q[AW-1:0]] <= w_wdata;
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_gnt_any) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (w_pop)     rd_ptr_q <= rd_ptr_q + c_ptr_one;
    end
  end

  // Sticky overflow; a new overflow beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= (ovf_q & ~ovf_clear_i) | (|w_ovf_set);
  end

  assign w_head         = mem_q[rd_ptr_q[AW-1:0]];
  assign evt_valid_o    = ~w_empty;
  assign evt_severity_o = evt_valid_o ? w_head[PW-1 -: 4]  : 4'h0;
  assign evt_code_o     = evt_valid_o ? w_head[SEGW +: 8]  : 8'h00;
  assign evt_seg_o      = evt_valid_o ? w_head[SEGW-1:0]   : '0;
  assign evt_overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fault_containment_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fault_containment_ctrl                                    |
// | Description : Directed bench; expected logger events are queued as the    |
// |               stimulus is issued and checked by an independent monitor.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fault_containment_ctrl;

  localparam int NS = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] seg_fault, seg_recov, fence, mask_iso, clr_lock;
  logic          ovf_clr, evt_ready;
  logic [NS-1:0] seg_allow, seg_srst, seg_locked;
  logic          evt_valid, evt_overflow;
  logic [3:0]    evt_sev;
  logic [7:0]    evt_code;
  logic [SW-1:0] evt_seg;

  typedef struct packed {
    logic [SW-1:0] seg;
    logic [7:0]    code;
    logic [3:0]    sev;
  } evt_t;

  evt_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  fault_containment_ctrl #(
    .NUM_SEG(NS), .EVT_DEPTH(4), .MAX_RETRY(3), .HOLDOFF_CYC(16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .seg_fault_i       (seg_fault),
    .seg_recoverable_i (seg_recov),
    .fence_enable_i    (fence),
    .mask_isolate_i    (mask_iso),
    .clear_lock_i      (clr_lock),
    .ovf_clear_i       (ovf_clr),
    .seg_allow_o       (seg_allow),
    .seg_soft_reset_o  (seg_srst),
    .seg_locked_o      (seg_locked),
    .evt_valid_o       (evt_valid),
    .evt_ready_i       (evt_ready),
    .evt_severity_o    (evt_sev),
    .evt_code_o        (evt_code),
    .evt_seg_o         (evt_seg),
    .evt_overflow_o    (evt_overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int seg, input logic [7:0] code, input logic [3:0] sev);
    evt_t e;
    e.seg  = SW'(seg);
    e.code = code;
    e.sev  = sev;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    seg_fault = '0; seg_recov = '0; clr_lock = '0; ovf_clr = 1'b0; evt_ready = 1'b0;
    rst = 1'b1;
    sb.delete();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    evt_ready = 1'b1;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    chk("drain_left", sb.size(), 0);
    cyc(2);
  endtask

  // Monitor: every accepted event is compared against the head of the scoreboard
  initial begin : monitor
    evt_t act, exp;
    forever begin
      @(negedge clk);
      if (!rst && evt_valid && evt_ready) begin
        act.seg = evt_seg; act.code = evt_code; act.sev = evt_sev;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL evt_unexpected: got seg %0d code %0h sev %0d expected none",
                   act.seg, act.code, act.sev);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL evt_payload: got seg %0d code %0h sev %0d expected seg %0d code %0h sev %0d",
                     act.seg, act.code, act.sev, exp.seg, exp.code, exp.sev);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit hold_ok;
    seg_fault = '0; seg_recov = '0; fence = 8'hFF; mask_iso = '0; clr_lock = '0;
    ovf_clr = 1'b0; evt_ready = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Reset values
    chk("rst_allow",  seg_allow, 8'hFF);
    chk("rst_srst",   seg_srst, 8'h00);
    chk("rst_locked", seg_locked, 8'h00);
    chk("rst_valid",  evt_valid, 0);
    chk("rst_payload", {evt_sev, evt_code, evt_seg}, 0);
    chk("rst_ovf",    evt_overflow, 0);

    // T1: fence, fault/recover, hold-off length
    evt_ready = 1'b1;
    seg_fault = 8'h04; push(2, 8'hF1, 4'd2); cyc(1); seg_fault = '0;
    chk("t1_allow_fault", seg_allow, 8'hFB);
    chk("t1_valid_lat1", evt_valid, 0);
    cyc(1);
    chk("t1_valid_lat2", evt_valid, 1);
    seg_recov = 8'h04; push(2, 8'hF2, 4'd1); cyc(1); seg_recov = '0;
    chk("t1_srst", seg_srst, 8'h04);
    chk("t1_allow_hold", seg_allow, 8'hFB);
    hold_ok = 1'b1;
    for (int j = 0; j < 15; j++) begin
      cyc(1);
      if (seg_allow[2] !== 1'b0 || seg_srst !== 8'h00) hold_ok = 1'b0;
    end
    chk("t1_hold_gated", hold_ok, 1);
    cyc(1);
    chk("t1_allow_back", seg_allow, 8'hFF);
    drain(20);

    // T2: simultaneous faults serialised round-robin; seg 5 unfenced
    do_reset();
    evt_ready = 1'b1; fence = 8'hDF;
    seg_fault = 8'h29;
    push(0, 8'hF1, 4'd2); push(3, 8'hF1, 4'd2); push(5, 8'hF1, 4'd2);
    cyc(1); seg_fault = '0;
    chk("t2_allow", seg_allow, 8'hF6);
    cyc(1); chk("t2_head0", {evt_valid, evt_seg}, {1'b1, 3'd0});
    cyc(1); chk("t2_head1", {evt_valid, evt_seg}, {1'b1, 3'd3});
    cyc(1); chk("t2_head2", {evt_valid, evt_seg}, {1'b1, 3'd5});
    chk("t2_ovf", evt_overflow, 0);
    drain(20);
    fence = 8'hFF;

    // T3: six events into a 4-deep FIFO with the logger stalled
    do_reset();
    seg_fault = 8'h3F;
    for (int s = 0; s < 6; s++) push(s, 8'hF1, 4'd2);
    cyc(1); seg_fault = '0;
    cyc(5);
    chk("t3_head", {evt_valid, evt_seg, evt_code}, {1'b1, 3'd0, 8'hF1});
    cyc(3);
    chk("t3_stable", {evt_valid, evt_seg, evt_sev}, {1'b1, 3'd0, 4'd2});
    chk("t3_ovf", evt_overflow, 0);
    drain(30);
    chk("t3_ovf_after", evt_overflow, 0);

    // T4: overwrite of a blocked slot, clear races
    do_reset();
    seg_fault = 8'h1D;
    push(0, 8'hF1, 4'd2); push(2, 8'hF1, 4'd2); push(3, 8'hF1, 4'd2); push(4, 8'hF1, 4'd2);
    cyc(1); seg_fault = '0;
    cyc(4);
    seg_fault = 8'h02; cyc(1); seg_fault = '0;
    chk("t4_ovf_pending", evt_overflow, 0);
    seg_recov = 8'h02; cyc(1); seg_recov = '0;
    chk("t4_ovf_set", evt_overflow, 1);
    seg_fault = 8'h02; ovf_clr = 1'b1; cyc(1); seg_fault = '0; ovf_clr = 1'b0;
    chk("t4_ovf_race", evt_overflow, 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("t4_ovf_clear", evt_overflow, 0);
    push(1, 8'hF1, 4'd2);
    drain(30);

    // T5: repeated faults on an isolated segment
    do_reset();
    evt_ready = 1'b1; mask_iso = 8'h10;
    for (int r = 0; r < 3; r++) begin
      seg_fault = 8'h10; push(4, 8'hF1, 4'd2); cyc(1); seg_fault = '0;
      seg_recov = 8'h10; push(4, 8'hF3, 4'd1); cyc(1); seg_recov = '0;
    end
`ifdef FAULT_CONTAIN_LOCKOUT_EN
    seg_fault = 8'h10; push(4, 8'hF4, 4'd3); cyc(1); seg_fault = '0;
    chk("t5_locked", seg_locked, 8'h10);
    chk("t5_allow_lock", seg_allow, 8'hEF);
    seg_recov = 8'h10; cyc(1); seg_recov = '0;
    chk("t5_recov_ignored", {seg_locked, seg_srst}, {8'h10, 8'h00});
    clr_lock = 8'h10; push(4, 8'hF5, 4'd1); cyc(1); clr_lock = '0;
    chk("t5_unlock", {seg_locked, seg_allow}, {8'h00, 8'hFF});
`else
    seg_fault = 8'h10; push(4, 8'hF1, 4'd2); cyc(1); seg_fault = '0;
    chk("t5_no_lock", seg_locked, 8'h00);
    chk("t5_allow_iso", seg_allow, 8'hEF);
    seg_recov = 8'h10; push(4, 8'hF3, 4'd1); cyc(1); seg_recov = '0;
    chk("t5_srst", seg_srst, 8'h10);
    clr_lock = 8'h10; cyc(1); clr_lock = '0;
    chk("t5_clr_noeffect", seg_allow, 8'hEF);
`endif
    drain(20);
    chk("t5_ovf", evt_overflow, 0);
    mask_iso = '0;

    // T6: asynchronous reset with events queued
    do_reset();
    seg_fault = 8'h07; cyc(1); seg_fault = '0;
    cyc(4);
    chk("t6_queued", evt_valid, 1);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("t6_valid", evt_valid, 0);
    chk("t6_allow", seg_allow, 8'hFF);
    chk("t6_flags", {seg_srst, seg_locked, evt_overflow}, 0);
    chk("t6_payload", {evt_sev, evt_code, evt_seg}, 0);
    cyc(1);
    rst = 1'b0; evt_ready = 1'b1;
    cyc(10);
    chk("t6_no_stale", evt_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
